// File: rtl/monitor_bridge_pkg.sv
// rtl/monitor_bridge_pkg.sv - shared types/constants for monitor_mem_bridge; MONITOR_BRIDGE_SYNC_EN selects sync depth
package monitor_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        LATCH  = 2'd3
    } bridge_state_e;

    localparam int RD_LAT_DEFAULT = 1;

`ifdef MONITOR_BRIDGE_SYNC_EN
    localparam int SYNC_DEPTH = 2;
`else
    localparam int SYNC_DEPTH = 1;
`endif

endpackage

// File: rtl/monitor_mem_bridge_if.sv
// rtl/monitor_mem_bridge_if.sv - simple address/write-data/write-enable/read-data memory port
interface monitor_mem_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    logic              we;
    logic [DATA_W-1:0] rd;

    modport master (output addr, output wd, output we, input  rd);
    modport slave  (input  addr, input  wd, input  we, output rd);
endinterface

// File: rtl/monitor_mem_bridge_sync_edge_detect.sv
// rtl/monitor_mem_bridge_sync_edge_detect.sv - synchronizer, arming and rising-edge pulse for the monitor port clock
module sync_edge_detect
    import monitor_bridge_pkg::*;
#(
    parameter int DEPTH = SYNC_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic [DEPTH-1:0] sync_q;
    logic             prev_q;
    logic             armed_q;

    // Sync chain and previous sample reset high so a port clock held high
    // across reset never looks like a rising edge; arming needs a real low.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '1;
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[DEPTH-1];
            if (!sync_q[DEPTH-1]) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign rise = armed_q & sync_q[DEPTH-1] & ~prev_q;

endmodule

// File: rtl/monitor_mem_bridge.sv
// rtl/monitor_mem_bridge.sv - monitor/CPU memory port bridge; sync depth set by MONITOR_BRIDGE_SYNC_EN
module monitor_mem_bridge
    import monitor_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = RD_LAT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 prg_mode,
    input  logic                 mon_clk,
    monitor_mem_bridge_if.slave  mon,
    monitor_mem_bridge_if.slave  cpu,
    monitor_mem_bridge_if.master mem,
    output logic                 busy,
    output logic                 overrun
);

    localparam logic [1:0] WAIT_INIT = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

    logic                  mon_rise;
    logic [SYNC_DEPTH-1:0] prg_sync_q;
    logic                  mode_q;
    bridge_state_e         state_q;
    logic [1:0]            wait_cnt_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wd_q;
    logic                  we_q;
    logic [DATA_W-1:0]     mon_rd_q;
    logic                  busy_q;
    logic                  overrun_q;

    sync_edge_detect #(
        .DEPTH (SYNC_DEPTH)
    ) u_mon_clk_edge (
        .clk   (clk),
        .reset (reset),
        .d     (mon_clk),
        .rise  (mon_rise)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            prg_sync_q <= '0;
            mode_q     <= 1'b0;
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            wd_q       <= '0;
            we_q       <= 1'b0;
            mon_rd_q   <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            prg_sync_q[0] <= prg_mode;
            for (int i = 1; i < SYNC_DEPTH; i++) begin
                prg_sync_q[i] <= prg_sync_q[i-1];
            end
            mode_q <= prg_sync_q[SYNC_DEPTH-1];

            if (mon_rise && busy_q) begin
                overrun_q <= 1'b1;
            end

            // Losing program mode abandons the transaction; the mux already
            // hands the memory back to the CPU, so no late write can escape.
            if (!mode_q) begin
                state_q <= IDLE;
                we_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (mon_rise) begin
                            addr_q  <= mon.addr;
                            wd_q    <= mon.wd;
                            we_q    <= mon.we;
                            busy_q  <= 1'b1;
                            state_q <= ACCESS;
                        end
                    end
                    ACCESS: begin
                        we_q <= 1'b0;
                        if (RD_LAT == 1) begin
                            state_q <= LATCH;
                        end else begin
                            wait_cnt_q <= WAIT_INIT;
                            state_q    <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (wait_cnt_q == 2'd0) begin
                            state_q <= LATCH;
                        end else begin
                            wait_cnt_q <= wait_cnt_q - 2'd1;
                        end
                    end
                    LATCH: begin
                        mon_rd_q <= mem.rd;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // Idle in program mode keeps the last monitor address with we low.
    assign mem.addr = mode_q ? addr_q : cpu.addr;
    assign mem.wd   = mode_q ? wd_q   : cpu.wd;
    assign mem.we   = mode_q ? we_q   : cpu.we;
    assign cpu.rd   = mode_q ? '0     : mem.rd;
    assign mon.rd   = mon_rd_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_monitor_mem_bridge.sv
// tb/tb_monitor_mem_bridge.sv - randomized self-checking bench for monitor_mem_bridge
module tb_monitor_mem_bridge;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 1;
`ifdef MONITOR_BRIDGE_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic prg_mode = 1'b0;
    logic mon_clk  = 1'b0;
    logic busy;
    logic overrun;

    monitor_mem_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mon_if ();
    monitor_mem_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_if ();
    monitor_mem_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    monitor_mem_bridge #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .prg_mode (prg_mode),
        .mon_clk  (mon_clk),
        .mon      (mon_if),
        .cpu      (cpu_if),
        .mem      (mem_if),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // External single-port memory: read-old on read-during-write
    logic [DATA_W-1:0] mem_arr [0:255];
    logic [DATA_W-1:0] rd_pipe [0:RD_LAT-1];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= '0;
            for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
        end else begin
            rd_pipe[0] <= mem_arr[mem_if.addr[7:0]];
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
            if (mem_if.we) mem_arr[mem_if.addr[7:0]] <= mem_if.wd;
        end
    end
    assign mem_if.rd = rd_pipe[RD_LAT-1];

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] ref_mem [0:255];
    logic [DATA_W-1:0] exp_mon_rd;
    logic [ADDR_W-1:0] last_we_addr;
    logic [DATA_W-1:0] last_we_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        exp_mon_rd = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clear_ref();
    endtask

    // One monitor access: raise mon_clk, hold it high through the window,
    // record we pulses, busy cycles and first cycle mon_rd shows exp_rd.
    task automatic mon_access(input logic [7:0] a, input logic [31:0] d, input logic w,
                              input logic [31:0] exp_rd, output int we_n, output int we_at,
                              output int busy_n, output int rd_at);
        @(negedge clk);
        mon_if.addr = {24'h0, a};
        mon_if.wd   = d;
        mon_if.we   = w;
        mon_clk     = 1'b1;
        we_n = 0; we_at = -1; busy_n = 0; rd_at = -1;
        for (int n = 1; n <= S + RD_LAT + 8; n++) begin
            @(negedge clk);
            if (mem_if.we) begin
                we_n++;
                if (we_at < 0) we_at = n;
                last_we_addr = mem_if.addr;
                last_we_data = mem_if.wd;
            end
            if (busy) busy_n++;
            if (rd_at < 0 && mon_if.rd == exp_rd) rd_at = n;
        end
        mon_clk = 1'b0;
        repeat (S + 2) @(negedge clk);
    endtask

    initial begin
        int we_n, we_at, busy_n, rd_at, cnt, bcnt;
        logic [7:0]  a;
        logic [7:0]  last_a;
        logic [31:0] d, e;
        logic        w;

        cpu_if.addr = 32'h55; cpu_if.wd = '0; cpu_if.we = 1'b0;
        mon_if.addr = '0;     mon_if.wd = '0;  mon_if.we = 1'b0;
        clear_ref();
        last_we_addr = '0; last_we_data = '0;

        repeat (3) @(negedge clk);
        check("rst_mon_rd", mon_if.rd, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_mem_addr_cpu", mem_if.addr, 32'h55);

        reset = 1'b0;
        prg_mode = 1'b1;
        repeat (S + 6) @(negedge clk);

        mon_access(8'h10, 32'hDEADBEEF, 1'b1, 32'h0, we_n, we_at, busy_n, rd_at);
        check("wr_we_count", we_n, 1);
        check("wr_we_at", we_at, S + 1);
        check("wr_addr", last_we_addr, 32'h10);
        check("wr_data", last_we_data, 32'hDEADBEEF);
        check("wr_mon_rd", mon_if.rd, 32'h0);
        ref_mem[8'h10] = 32'hDEADBEEF;

        mon_access(8'h10, 32'h0, 1'b0, 32'hDEADBEEF, we_n, we_at, busy_n, rd_at);
        check("rd_we_count", we_n, 0);
        check("rd_latency", rd_at, S + 2 + RD_LAT);
        check("rd_busy_cycles", busy_n, RD_LAT + 1);
        check("rd_mon_rd", mon_if.rd, 32'hDEADBEEF);
        exp_mon_rd = 32'hDEADBEEF;
        last_a = 8'h10;

        for (int k = 0; k < 20; k++) begin
            a = 8'($urandom_range(0, 15));
            d = $urandom;
            w = 1'($urandom_range(0, 1));
            e = ref_mem[a];
            mon_access(a, d, w, e, we_n, we_at, busy_n, rd_at);
            check("rnd_we_count", we_n, {31'h0, w});
            check("rnd_busy_cycles", busy_n, RD_LAT + 1);
            check("rnd_mon_rd", mon_if.rd, e);
            if (w) begin
                check("rnd_wr_addr", last_we_addr, {24'h0, a});
                check("rnd_wr_data", last_we_data, d);
                ref_mem[a] = d;
            end
            exp_mon_rd = e;
            last_a = a;
        end
        check("rnd_overrun", overrun, 0);

        cpu_if.addr = 32'hABC; cpu_if.wd = 32'h1; cpu_if.we = 1'b1;
        @(negedge clk);
        check("hold_mem_addr", mem_if.addr, {24'h0, last_a});
        check("hold_mem_we", mem_if.we, 0);
        check("hold_cpu_rd", cpu_if.rd, 0);
        cpu_if.we = 1'b0;

        prg_mode = 1'b0;
        repeat (S + 3) @(negedge clk);
        cpu_if.addr = 32'h20; cpu_if.wd = 32'h5; cpu_if.we = 1'b1;
        #1;
        check("cpu_mem_addr", mem_if.addr, 32'h20);
        check("cpu_mem_wd", mem_if.wd, 32'h5);
        check("cpu_mem_we", mem_if.we, 1);
        @(negedge clk);
        ref_mem[8'h20] = 32'h5;
        cpu_if.we = 1'b0;
        repeat (RD_LAT + 1) @(negedge clk);
        check("cpu_rd_value", cpu_if.rd, 32'h5);
        check("cpu_rd_follows_mem", cpu_if.rd, mem_if.rd);

        for (int k = 0; k < 6; k++) begin
            a = 8'(32'h20 + $urandom_range(0, 15));
            d = $urandom;
            @(negedge clk);
            cpu_if.addr = {24'h0, a}; cpu_if.wd = d; cpu_if.we = 1'b1;
            @(negedge clk);
            ref_mem[a] = d;
            cpu_if.we = 1'b0;
            a = 8'(32'h20 + $urandom_range(0, 15));
            cpu_if.addr = {24'h0, a};
            repeat (RD_LAT + 1) @(negedge clk);
            check("cpu_rnd_rd", cpu_if.rd, ref_mem[a]);
        end

        cnt = 0; bcnt = 0;
        for (int k = 0; k < 3; k++) begin
            mon_clk = 1'b1;
            repeat (4) begin @(negedge clk); if (mem_if.we) cnt++; if (busy) bcnt++; end
            mon_clk = 1'b0;
            repeat (4) begin @(negedge clk); if (mem_if.we) cnt++; if (busy) bcnt++; end
        end
        check("mode0_edge_we", cnt, 0);
        check("mode0_edge_busy", bcnt, 0);
        check("mode0_overrun", overrun, 0);

        prg_mode = 1'b1;
        repeat (S + 4) @(negedge clk);
        mon_if.addr = 32'h30; mon_if.wd = 32'h12345678; mon_if.we = 1'b1;
        mon_clk = 1'b1;
        prg_mode = 1'b0;
        cnt = 0;
        repeat (10) begin @(negedge clk); if (mem_if.we) cnt++; end
        check("drop_we", cnt, 0);
        check("drop_busy", busy, 0);
        check("drop_mon_rd", mon_if.rd, exp_mon_rd);
        mon_clk = 1'b0;
        prg_mode = 1'b1;
        repeat (S + 4) @(negedge clk);
        mon_access(8'h30, 32'h0, 1'b0, ref_mem[8'h30], we_n, we_at, busy_n, rd_at);
        check("drop_mem_unchanged", mon_if.rd, ref_mem[8'h30]);

        @(negedge clk);
        mon_if.addr = 32'h40; mon_if.wd = 32'hCAFE0001; mon_if.we = 1'b1;
        mon_clk = 1'b1;
        cnt = 0;
        @(negedge clk); if (mem_if.we) cnt++;
        mon_clk = 1'b0;
        @(negedge clk); if (mem_if.we) cnt++;
        mon_clk = 1'b1;
        repeat (10) begin @(negedge clk); if (mem_if.we) cnt++; end
        check("ovr_single_access", cnt, 1);
        check("ovr_flag", overrun, 1);
        ref_mem[8'h40] = 32'hCAFE0001;
        mon_clk = 1'b0;
        repeat (S + 2) @(negedge clk);
        mon_access(8'h40, 32'h0, 1'b0, 32'hCAFE0001, we_n, we_at, busy_n, rd_at);
        check("ovr_readback", mon_if.rd, 32'hCAFE0001);
        check("ovr_sticky", overrun, 1);

        mon_clk = 1'b1;
        prg_mode = 1'b1;
        do_reset();
        check("rst2_overrun", overrun, 0);
        cnt = 0; bcnt = 0;
        repeat (12) begin @(negedge clk); if (mem_if.we) cnt++; if (busy) bcnt++; end
        check("held_high_no_we", cnt, 0);
        check("held_high_no_busy", bcnt, 0);
        mon_clk = 1'b0;
        repeat (S + 2) @(negedge clk);
        d = $urandom;
        mon_access(8'h11, d, 1'b1, 32'h0, we_n, we_at, busy_n, rd_at);
        check("rearm_we_count", we_n, 1);
        check("rearm_wr_data", last_we_data, d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
